// File: rtl/mem_access_ctrl_if.sv
// mem_access_ctrl_if: request/response handshake and memory-bank bus between the control unit, the sequencer and the bank
interface mem_access_ctrl_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_is_load;
  logic [DATA_W-1:0] rsp_rdata;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_data_in;
  logic              mem_read;
  logic              mem_write;
  logic [DATA_W-1:0] mem_data_out;
  modport master (
    output req_valid, req_write, req_addr, req_wdata, rsp_ready, mem_data_out,
    input  req_ready, rsp_valid, rsp_is_load, rsp_rdata, mem_address, mem_data_in, mem_read, mem_write
  );
  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, rsp_ready, mem_data_out,
    output req_ready, rsp_valid, rsp_is_load, rsp_rdata, mem_address, mem_data_in, mem_read, mem_write
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: load/store sequencer driving a fixed-latency memory bank with one-cycle strobes.
// Optional completion counters enabled by MEM_ACCESS_CTRL_STATS_EN.
module mem_access_ctrl #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 16,
  parameter int MEM_LATENCY = 1
) (
  input  logic                 CLK,
  input  logic                 RST,
  mem_access_ctrl_if.slave     bus,
  output logic [15:0]          load_count,
  output logic [15:0]          store_count
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t            state, state_d;
  logic              op_write, op_write_d;
  logic [3:0]        wait_cnt, wait_cnt_d;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] din_d, rdata_d;
  logic              rd_d, wr_d;
  always_comb begin
    state_d    = state;
    op_write_d = op_write;
    wait_cnt_d = wait_cnt;
    addr_d     = bus.mem_address;
    din_d      = bus.mem_data_in;
    rdata_d    = bus.rsp_rdata;
    rd_d       = 1'b0;
    wr_d       = 1'b0;
    case (state)
      IDLE: if (bus.req_valid) begin
        state_d    = ISSUE;
        op_write_d = bus.req_write;
        addr_d     = bus.req_addr;
        din_d      = bus.req_wdata;
        rd_d       = !bus.req_write;
        wr_d       = bus.req_write;
      end
      ISSUE: begin
        state_d    = WAIT;
        wait_cnt_d = 4'(MEM_LATENCY);
      end
      WAIT: begin
        wait_cnt_d = wait_cnt - 4'd1;
        // data_out is only driven in the last latency cycle; sample nowhere else
        if (wait_cnt == 4'd1) begin
          state_d = RESP;
          rdata_d = op_write ? bus.rsp_rdata : bus.mem_data_out;
        end
      end
      RESP: state_d = bus.rsp_ready ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state           <= IDLE;
      op_write        <= 1'b0;
      wait_cnt        <= '0;
      bus.req_ready   <= 1'b1;
      bus.rsp_valid   <= 1'b0;
      bus.rsp_is_load <= 1'b0;
      bus.rsp_rdata   <= '0;
      bus.mem_address <= '0;
      bus.mem_data_in <= '0;
      bus.mem_read    <= 1'b0;
      bus.mem_write   <= 1'b0;
    end else begin
      state           <= state_d;
      op_write        <= op_write_d;
      wait_cnt        <= wait_cnt_d;
      bus.req_ready   <= state_d == IDLE;
      bus.rsp_valid   <= state_d == RESP;
      bus.rsp_is_load <= state_d == RESP && !op_write_d;
      bus.rsp_rdata   <= rdata_d;
      bus.mem_address <= addr_d;
      bus.mem_data_in <= din_d;
      bus.mem_read    <= rd_d;
      bus.mem_write   <= wr_d;
    end
  end
`ifdef MEM_ACCESS_CTRL_STATS_EN
  logic retire;
  assign retire = state == RESP && bus.rsp_ready;
  always_ff @(posedge CLK) begin
    if (RST) begin
      load_count  <= '0;
      store_count <= '0;
    end else if (retire) begin
      load_count  <= (!op_write && !(&load_count)) ? load_count + 16'd1 : load_count;
      store_count <= (op_write && !(&store_count)) ? store_count + 16'd1 : store_count;
    end
  end
`else
  assign load_count  = 16'h0000;
  assign store_count = 16'h0000;
`endif
endmodule
